// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control path: sequencer state encoding,
// the hard-wired zero register specifier and the NOP word loaded into fd on a flush.
package pipeline_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } hazard_state_e;

  localparam int unsigned REG_W_DEFAULT = 5;
  localparam logic [REG_W_DEFAULT-1:0] REG_ZERO = '0;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int unsigned REM_W = 3;

endpackage : pipeline_ctrl_pkg

// File: rtl/hazard_perf_counter.sv
// Free-running event counter for pipeline debug statistics; wraps modulo 2^CNT_W.
module hazard_perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc) count_d = count_q + CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; reset is synchronous, so it sits inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule : hazard_perf_counter

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: resolves load-use, taken-branch
// and data-memory-wait hazards and counts stall cycles and flush events.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned REG_W        = 5,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] fd_rs,
  input  logic [REG_W-1:0] fd_rt,
  input  logic             fd_uses_rt,
  input  logic             de_mem_read,
  input  logic [REG_W-1:0] de_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             fd_write,
  output logic             de_write,
  output logic             fd_flush,
  output logic             de_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [REM_W-1:0] REM_INIT = REM_W'(FLUSH_CYCLES - 1);
  localparam logic [REG_W-1:0] ZERO_REG = REG_W'(REG_ZERO);

  hazard_state_e    state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;

  logic load_use;
  logic stall_inc;
  logic flush_inc;

  // Register 0 is hard-wired, so a load targeting it never creates a dependency.
  assign load_use = de_mem_read && (de_rt != ZERO_REG) &&
                    ((de_rt == fd_rs) || (fd_uses_rt && (de_rt == fd_rt)));

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    pc_write  = 1'b1;
    fd_write  = 1'b1;
    de_write  = 1'b1;
    fd_flush  = 1'b0;
    de_flush  = 1'b0;
    flush_inc = 1'b0;

    if (rst) begin
      state_d  = RUN;
      rem_d    = '0;
      pc_write = 1'b0;
      fd_write = 1'b0;
      de_write = 1'b0;
      fd_flush = 1'b1;
      de_flush = 1'b1;
    end else if (mem_busy) begin
      // Frozen pipeline keeps presenting any branch/load-use until the wait ends.
      pc_write = 1'b0;
      fd_write = 1'b0;
      de_write = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (ex_branch_taken) begin
            fd_flush  = 1'b1;
            de_flush  = 1'b1;
            flush_inc = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              rem_d   = REM_INIT;
            end
          end else if (load_use) begin
            pc_write = 1'b0;
            fd_write = 1'b0;
            de_flush = 1'b1;
          end
        end
        FLUSH: begin
          fd_flush = 1'b1;
          rem_d    = rem_q - REM_W'(1);
          if (rem_q <= REM_W'(1)) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign stall_inc = !rst && !pc_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_count)
  );

  hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule : pipeline_hazard_controller

// File: tb/tb_pipeline_hazard_controller.sv
// Directed self-checking bench for pipeline_hazard_controller with
// FLUSH_CYCLES=3 and 4-bit counters so wrap-around is reachable.
module tb_pipeline_hazard_controller;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] fd_rs, fd_rt, de_rt;
  logic             fd_uses_rt, de_mem_read, ex_branch_taken, mem_busy;
  logic             pc_write, fd_write, de_write, fd_flush, de_flush;
  logic [CNT_W-1:0] stall_count, flush_count;

  int n_asserts = 0;
  int n_fail    = 0;

  pipeline_hazard_controller #(
    .FLUSH_CYCLES (3),
    .REG_W        (REG_W),
    .CNT_W        (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fd_rs           (fd_rs),
    .fd_rt           (fd_rt),
    .fd_uses_rt      (fd_uses_rt),
    .de_mem_read     (de_mem_read),
    .de_rt           (de_rt),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .pc_write        (pc_write),
    .fd_write        (fd_write),
    .de_write        (de_write),
    .fd_flush        (fd_flush),
    .de_flush        (de_flush),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control vector order: {pc_write, fd_write, de_write, fd_flush, de_flush}
  task automatic ctl(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, pc_write, fd_write, de_write, fd_flush, de_flush}, {27'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset dominates a simultaneous memory wait and taken branch
    rst = 1'b1; mem_busy = 1'b1; ex_branch_taken = 1'b1;
    de_mem_read = 1'b0; de_rt = '0; fd_rs = '0; fd_rt = '0; fd_uses_rt = 1'b0;
    #1; ctl("rst_c0", 5'b00011); step();
    #1; ctl("rst_c1", 5'b00011); step();
    rst = 1'b0; mem_busy = 1'b0; ex_branch_taken = 1'b0;
    #1;
    chk("rst_stall_cnt", 32'(stall_count), 32'd0);
    chk("rst_flush_cnt", 32'(flush_count), 32'd0);
    ctl("run_idle", 5'b11100);
    step();

    // Load-use through rs: one bubble cycle
    de_mem_read = 1'b1; de_rt = 5'd8; fd_rs = 5'd8;
    #1; ctl("lu_rs", 5'b00101); step();
    de_mem_read = 1'b0;
    #1; ctl("lu_rs_cleared", 5'b11100); chk("lu_rs_stall_cnt", 32'(stall_count), 32'd1); step();

    // Load to register 0 never stalls
    de_mem_read = 1'b1; de_rt = 5'd0; fd_rs = 5'd0;
    #1; ctl("lu_r0", 5'b11100); step();
    chk("lu_r0_stall_cnt", 32'(stall_count), 32'd1);

    // rt match only counts when fd actually reads rt
    de_rt = 5'd9; fd_rt = 5'd9; fd_rs = 5'd3; fd_uses_rt = 1'b0;
    #1; ctl("rt_unused", 5'b11100); step();
    fd_uses_rt = 1'b1;
    #1; ctl("rt_used", 5'b00101); step();
    chk("rt_stall_cnt", 32'(stall_count), 32'd2);

    // Taken branch with simultaneous load-use: flush wins, 3 fd flush cycles
    ex_branch_taken = 1'b1;
    #1; ctl("br_c0", 5'b11111); step();
    ex_branch_taken = 1'b0;
    #1; ctl("br_c1", 5'b11110); chk("br_flush_cnt", 32'(flush_count), 32'd1); step();
    #1; ctl("br_c2", 5'b11110); step();
    de_mem_read = 1'b0;
    #1; ctl("br_done", 5'b11100); chk("br_stall_cnt", 32'(stall_count), 32'd2); step();

    // Memory wait in FLUSH with rem=2 freezes everything and holds rem
    ex_branch_taken = 1'b1;
    #1; ctl("mw_br", 5'b11111); step();
    ex_branch_taken = 1'b0; mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; ctl($sformatf("mw_busy%0d", i), 5'b00000); step();
    end
    mem_busy = 1'b0;
    #1;
    chk("mw_stall_cnt", 32'(stall_count), 32'd6);
    chk("mw_flush_cnt", 32'(flush_count), 32'd2);
    ctl("mw_fl1", 5'b11110);
    step();
    ex_branch_taken = 1'b1;  // ignored while flushing
    #1; ctl("mw_fl2_br_ignored", 5'b11110); step();
    ex_branch_taken = 1'b0;
    #1; ctl("mw_run", 5'b11100); chk("mw_flush_cnt2", 32'(flush_count), 32'd2); step();

    // Reset mid-FLUSH returns to RUN and clears counters
    ex_branch_taken = 1'b1;
    #1; step();
    ex_branch_taken = 1'b0; rst = 1'b1;
    #1; ctl("midrst", 5'b00011); step();
    rst = 1'b0;
    #1;
    ctl("midrst_run", 5'b11100);
    chk("midrst_stall_cnt", 32'(stall_count), 32'd0);
    chk("midrst_flush_cnt", 32'(flush_count), 32'd0);
    step();

    // Memory wait defers a load-use; it stalls once the wait ends
    de_mem_read = 1'b1; de_rt = 5'd8; fd_rs = 5'd8; fd_uses_rt = 1'b0; mem_busy = 1'b1;
    #1; ctl("defer_busy", 5'b00000); step();
    mem_busy = 1'b0;
    #1; ctl("defer_lu", 5'b00101); step();
    chk("defer_stall_cnt", 32'(stall_count), 32'd2);

    // Counter wrap: 14 more stalls reach 16 -> 0, then one more -> 1
    for (int i = 0; i < 14; i++) step();
    chk("wrap_zero", 32'(stall_count), 32'd0);
    step();
    chk("wrap_one", 32'(stall_count), 32'd1);
    de_mem_read = 1'b0;
    #1; ctl("final_run", 5'b11100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule : tb_pipeline_hazard_controller
